multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Main control FSM for the multicycle RV32I core.
- Sequences fetch, decode, execute, memory and writeback over several cycles. Drives the datapath mux selects and write enables.
- Supplies the 2-bit aluOp consumed by the ALU decoder.
- Adds a memory-ready handshake and an illegal-opcode trap.

Parameters:
- RESET_PC_HOLD, 0, number of extra cycles to hold FETCH after reset release before the first fetch is allowed (0 = fetch immediately).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- op  input  7  instr[6:0] from the instruction register
- zero  input  1  ALU zero flag for the branch decision
- memReady  input  1  memory completed the current access this cycle
- pcWrite  output  1  PC register enable
- adrSrc  output  1  memory address select: 0 = PC, 1 = result
- memWrite  output  1  data memory write strobe
- irWrite  output  1  instruction register and oldPC load
- resultSrc  output  2  00 = aluOut, 01 = memory data, 10 = aluResult
- aluSrcA  output  2  00 = PC, 01 = oldPC, 10 = rs1 data
- aluSrcB  output  2  00 = rs2 data, 01 = immExt, 10 = constant 4
- aluOp  output  2  00 = add, 01 = branch compare, 10 = funct-decoded
- regWrite  output  1  register file write enable
- instrDone  output  1  one-cycle pulse on the final cycle of each instruction
- illegal  output  1  high while in TRAP

Behaviour:
- States:
  - FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE
  - EXECR, EXECI, ALUWB, BEQ, JAL, TRAP
- 4-bit state register, asynchronous reset to FETCH.
- Reset:
  - While reset=1, every output is 0 regardless of state.
  - When reset is asserted mid-instruction, the FSM aborts to FETCH immediately. No partial writeback completes after that.
  - After release, a hold counter stalls in FETCH for RESET_PC_HOLD cycles with all outputs 0.
- Outputs are Moore (decoded from state), except pcWrite and the handshake-gated strobes.
- Unlisted outputs are 0 in each state.
- FETCH:
  - adrSrc=0, aluSrcA=00, aluSrcB=10, aluOp=00, resultSrc=10.
  - irWrite=memReady; pcUpdate=memReady.
  - Next state: DECODE if memReady=1, else stay.
- DECODE: aluSrcA=01, aluSrcB=01, aluOp=00 (branch target computed). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - any other value -> TRAP
- MEMADR: aluSrcA=10, aluSrcB=01, aluOp=00. Next state: MEMREAD if op=0000011, else MEMWRITE.
- MEMREAD:
  - resultSrc=00, adrSrc=1.
  - Next state: MEMWB when memReady=1, else stay.
- MEMWRITE:
  - resultSrc=00, adrSrc=1, memWrite=1 for every cycle in the state. The address and data are held stable until memReady.
  - instrDone=memReady.
  - Next state: FETCH when memReady=1.
- MEMWB: resultSrc=01, regWrite=1, instrDone=1. Next state: FETCH.
- EXECR: aluSrcA=10, aluSrcB=00, aluOp=10. Next state: ALUWB.
- EXECI: aluSrcA=10, aluSrcB=01, aluOp=10. Next state: ALUWB.
- ALUWB: resultSrc=00, regWrite=1, instrDone=1. Next state: FETCH.
- BEQ:
  - aluSrcA=10, aluSrcB=00, aluOp=01, resultSrc=00, branch=1, instrDone=1.
  - Next state: FETCH.
- JAL:
  - aluSrcA=01, aluSrcB=10, aluOp=00, resultSrc=00, pcUpdate=1.
  - Next state: ALUWB (writes rd = oldPC+4).
  - instrDone is asserted only in ALUWB.
- TRAP: illegal=1, all enables 0. Stays until reset.
- pcWrite = pcUpdate | (branch & zero). This is combinational from state, zero and memReady.
- Per-instruction cycle counts with memReady always 1:
  - lw 5, sw 4, R 4, I 4, beq 3, jal 4.
- Each memReady=0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.

Test Plan:
1. R-type add: op=0110011, memReady=1 -> states FETCH, DECODE, EXECR, ALUWB. aluOp=10 in EXECR. regWrite=1 and instrDone=1 only in ALUWB, cycle 4.
2. lw with memReady low for 2 cycles in MEMREAD: op=0000011 -> states FETCH, DECODE, MEMADR, MEMREAD×3, MEMWB. resultSrc=01 with regWrite=1 in MEMWB; 7 cycles total.
3. sw with a FETCH stall:
   - memReady=0 for 1 cycle in FETCH -> irWrite=0 and pcWrite=0 on that cycle.
   - Then memWrite=1 in MEMWRITE for exactly 1 cycle with adrSrc=1. regWrite never asserted.
4. beq:
   - zero=1 -> pcWrite=1 in the BEQ cycle.
   - Repeat with zero=0 -> pcWrite=0.
   - In both runs aluOp=01 and the FSM returns to FETCH.
5. Illegal opcode: op=1111111 -> DECODE then TRAP. illegal=1 and held for 10+ cycles with all enables 0; reset pulse returns the FSM to FETCH.
6. Async reset mid-MEMWRITE: assert reset between clock edges -> memWrite drops to 0 without waiting for a clock edge. After release with RESET_PC_HOLD=2, FETCH holds irWrite=0 for 2 cycles, then fetches normally.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Main sequencing FSM for the multicycle RV32I core: walks each instruction through
// fetch/decode/execute/memory/writeback and drives the datapath selects and enables.
//
// state    | meaning
// FETCH    | read instruction at PC, load IR/oldPC and bump PC when memory is ready
// DECODE   | register read, branch target computed into aluOut
// MEMADR   | load/store address = rs1 + imm
// MEMREAD  | load access in progress, waits for memReady
// MEMWB    | loaded data written to rd
// MEMWRITE | store strobe held until memReady
// EXECR    | R-type ALU operation
// EXECI    | I-type ALU operation
// ALUWB    | ALU result written to rd
// BEQ      | compare rs1/rs2, take branch on zero
// JAL      | PC <= target, oldPC+4 computed for the link register
// TRAP     | illegal opcode, parked until reset
module multicycle_ctrl #(
  parameter int RESET_PC_HOLD = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       memReady,
  output logic       pcWrite,
  output logic       adrSrc,
  output logic       memWrite,
  output logic       irWrite,
  output logic [1:0] resultSrc,
  output logic [1:0] aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluOp,
  output logic       regWrite,
  output logic       instrDone,
  output logic       illegal
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    TRAP     = 4'd11
  } stateType;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam int HOLD_W = (RESET_PC_HOLD > 0) ? $clog2(RESET_PC_HOLD + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RESET_PC_HOLD);

  stateType state, nextState;
  logic [HOLD_W-1:0] holdCnt;
  logic holding;
  logic pcUpdate, branch;

  // Post-reset stall: down-counter reloaded by reset, fetch allowed at terminal count
  assign holding = (holdCnt != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= FETCH;
      holdCnt <= HOLD_INIT;
    end else begin
      state <= nextState;
      if (holding) holdCnt <= holdCnt - HOLD_W'(1);
    end
  end

  always_comb begin
    nextState = state;
    adrSrc    = 1'b0;
    memWrite  = 1'b0;
    irWrite   = 1'b0;
    resultSrc = 2'b00;
    aluSrcA   = 2'b00;
    aluSrcB   = 2'b00;
    aluOp     = 2'b00;
    regWrite  = 1'b0;
    instrDone = 1'b0;
    illegal   = 1'b0;
    pcUpdate  = 1'b0;
    branch    = 1'b0;
    case (state)
      FETCH: begin
        resultSrc = 2'b10;
        aluSrcB   = 2'b10;
        irWrite   = memReady;
        pcUpdate  = memReady;
        if (memReady) nextState = DECODE;
      end
      DECODE: begin
        aluSrcA = 2'b01;
        aluSrcB = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: nextState = MEMADR;
          OP_RTYPE:          nextState = EXECR;
          OP_ITYPE:          nextState = EXECI;
          OP_BRANCH:         nextState = BEQ;
          OP_JAL:            nextState = JAL;
          default:           nextState = TRAP;
        endcase
      end
      MEMADR: begin
        aluSrcA   = 2'b10;
        aluSrcB   = 2'b01;
        nextState = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        adrSrc = 1'b1;
        if (memReady) nextState = MEMWB;
      end
      MEMWB: begin
        resultSrc = 2'b01;
        regWrite  = 1'b1;
        instrDone = 1'b1;
        nextState = FETCH;
      end
      MEMWRITE: begin
        adrSrc    = 1'b1;
        memWrite  = 1'b1;
        instrDone = memReady;
        if (memReady) nextState = FETCH;
      end
      EXECR: begin
        aluSrcA   = 2'b10;
        aluOp     = 2'b10;
        nextState = ALUWB;
      end
      EXECI: begin
        aluSrcA   = 2'b10;
        aluSrcB   = 2'b01;
        aluOp     = 2'b10;
        nextState = ALUWB;
      end
      ALUWB: begin
        regWrite  = 1'b1;
        instrDone = 1'b1;
        nextState = FETCH;
      end
      BEQ: begin
        aluSrcA   = 2'b10;
        aluOp     = 2'b01;
        branch    = 1'b1;
        instrDone = 1'b1;
        nextState = FETCH;
      end
      JAL: begin
        aluSrcA   = 2'b01;
        aluSrcB   = 2'b10;
        pcUpdate  = 1'b1;
        nextState = ALUWB;
      end
      TRAP: begin
        illegal = 1'b1;
      end
      default: nextState = FETCH;
    endcase

    pcWrite = pcUpdate | (branch & zero);

    // Reset and the post-reset hold force every output low regardless of state
    if (reset || holding) begin
      nextState = FETCH;
      pcWrite   = 1'b0;
      adrSrc    = 1'b0;
      memWrite  = 1'b0;
      irWrite   = 1'b0;
      resultSrc = 2'b00;
      aluSrcA   = 2'b00;
      aluSrcB   = 2'b00;
      aluOp     = 2'b00;
      regWrite  = 1'b0;
      instrDone = 1'b0;
      illegal   = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction phase sequences expanded from the opcode and
// memReady stall schedule, with expected outputs looked up from the per-phase output table.
module tb_multicycle_ctrl;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BAD    = 7'b1111111;

  typedef enum int {
    P_HOLD, P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE,
    P_EXECR, P_EXECI, P_ALUWB, P_BEQ, P_JAL, P_TRAP
  } phaseE;

  typedef struct {
    phaseE      ph;
    logic [6:0] op;
    logic       z;
    logic       mr;
  } cycT;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [6:0] op = 7'd0;
  logic zero = 1'b0;
  logic memReady = 1'b0;
  logic pcWrite, adrSrc, memWrite, irWrite, regWrite, instrDone, illegal;
  logic [1:0] resultSrc, aluSrcA, aluSrcB, aluOp;
  logic [14:0] vec;

  int compared = 0;
  int mismatched = 0;
  int cycNo = 0;
  cycT q[$];

  multicycle_ctrl #(.RESET_PC_HOLD(2)) dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .memReady(memReady),
    .pcWrite(pcWrite), .adrSrc(adrSrc), .memWrite(memWrite), .irWrite(irWrite),
    .resultSrc(resultSrc), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
    .regWrite(regWrite), .instrDone(instrDone), .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign vec = {pcWrite, adrSrc, memWrite, irWrite, resultSrc, aluSrcA, aluSrcB, aluOp,
                regWrite, instrDone, illegal};

  // Output table per phase; bit order matches vec
  function automatic logic [14:0] phaseOut(phaseE ph, logic mr, logic z);
    logic pcW, adr, mw, ir, rw, id, il;
    logic [1:0] rs, a, b, ao;
    {pcW, adr, mw, ir, rw, id, il} = '0;
    {rs, a, b, ao} = '0;
    case (ph)
      P_FETCH:    begin rs = 2'b10; b = 2'b10; ir = mr; pcW = mr; end
      P_DECODE:   begin a = 2'b01; b = 2'b01; end
      P_MEMADR:   begin a = 2'b10; b = 2'b01; end
      P_MEMREAD:  adr = 1'b1;
      P_MEMWB:    begin rs = 2'b01; rw = 1'b1; id = 1'b1; end
      P_MEMWRITE: begin adr = 1'b1; mw = 1'b1; id = mr; end
      P_EXECR:    begin a = 2'b10; ao = 2'b10; end
      P_EXECI:    begin a = 2'b10; b = 2'b01; ao = 2'b10; end
      P_ALUWB:    begin rw = 1'b1; id = 1'b1; end
      P_BEQ:      begin a = 2'b10; ao = 2'b01; id = 1'b1; pcW = z; end
      P_JAL:      begin a = 2'b01; b = 2'b10; pcW = 1'b1; end
      P_TRAP:     il = 1'b1;
      default:    ;
    endcase
    return {pcW, adr, mw, ir, rs, a, b, ao, rw, id, il};
  endfunction

  task automatic checkVal(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  // z/mr < 0 means don't-care: randomised so the DUT must ignore it
  task automatic addStep(input phaseE ph, input logic [6:0] o, input int z, input int mr);
    cycT c;
    c.ph = ph;
    c.op = o;
    if (z < 0) c.z = 1'($urandom_range(1, 0)); else c.z = z[0];
    if (mr < 0) c.mr = 1'($urandom_range(1, 0)); else c.mr = mr[0];
    q.push_back(c);
  endtask

  task automatic addInstr(input logic [6:0] o, input logic z, input int fStall,
                          input int mStall, input int trapCyc, output int n);
    int s0;
    s0 = q.size();
    repeat (fStall) addStep(P_FETCH, o, -1, 0);
    addStep(P_FETCH, o, -1, 1);
    addStep(P_DECODE, o, -1, -1);
    case (o)
      OP_LOAD: begin
        addStep(P_MEMADR, o, -1, -1);
        repeat (mStall) addStep(P_MEMREAD, o, -1, 0);
        addStep(P_MEMREAD, o, -1, 1);
        addStep(P_MEMWB, o, -1, -1);
      end
      OP_STORE: begin
        addStep(P_MEMADR, o, -1, -1);
        repeat (mStall) addStep(P_MEMWRITE, o, -1, 0);
        addStep(P_MEMWRITE, o, -1, 1);
      end
      OP_RTYPE:  begin addStep(P_EXECR, o, -1, -1); addStep(P_ALUWB, o, -1, -1); end
      OP_ITYPE:  begin addStep(P_EXECI, o, -1, -1); addStep(P_ALUWB, o, -1, -1); end
      OP_BRANCH: addStep(P_BEQ, o, int'(z), -1);
      OP_JAL:    begin addStep(P_JAL, o, -1, -1); addStep(P_ALUWB, o, -1, -1); end
      default:   repeat (trapCyc) addStep(P_TRAP, o, -1, -1);
    endcase
    n = q.size() - s0;
  endtask

  // Entered and left just after a rising edge; compares on the falling edge
  task automatic runQueue(input int maxCyc);
    cycT c;
    for (int i = 0; i < maxCyc && q.size() > 0; i++) begin
      c = q.pop_front();
      op = c.op;
      zero = c.z;
      memReady = c.mr;
      @(negedge clk);
      compared++;
      if (vec !== phaseOut(c.ph, c.mr, c.z)) begin
        mismatched++;
        $display("FAIL %s cyc %0d: got %h required %h", c.ph.name(), cycNo, vec,
                 phaseOut(c.ph, c.mr, c.z));
      end
      cycNo++;
      @(posedge clk);
      #1;
    end
    q.delete();
  endtask

  task automatic doReset();
    reset = 1'b1;
    #1 checkVal("resetOutImmediate", 32'(vec), 0);
    @(posedge clk);
    @(negedge clk);
    checkVal("resetOutHeld", 32'(vec), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    addStep(P_HOLD, 7'd0, -1, -1);
    addStep(P_HOLD, 7'd0, -1, -1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Pin the output table with hand-derived vectors
    checkVal("pinFetchReady", 32'(phaseOut(P_FETCH, 1'b1, 1'b0)), 32'(15'b1_0_0_1_10_00_10_00_0_0_0));
    checkVal("pinFetchStall", 32'(phaseOut(P_FETCH, 1'b0, 1'b1)), 32'(15'b0_0_0_0_10_00_10_00_0_0_0));
    checkVal("pinBeqTaken",   32'(phaseOut(P_BEQ, 1'b0, 1'b1)),   32'(15'b1_0_0_0_00_10_00_01_0_1_0));
    checkVal("pinBeqNot",     32'(phaseOut(P_BEQ, 1'b1, 1'b0)),   32'(15'b0_0_0_0_00_10_00_01_0_1_0));
    checkVal("pinMemWb",      32'(phaseOut(P_MEMWB, 1'b0, 1'b0)), 32'(15'b0_0_0_0_01_00_00_00_1_1_0));
    checkVal("pinTrap",       32'(phaseOut(P_TRAP, 1'b1, 1'b1)),  32'(15'b0_0_0_0_00_00_00_00_0_0_1));

    #1 reset = 1'b1;
    #1 doReset();

    addInstr(OP_RTYPE, 1'b0, 0, 0, 0, n);
    checkVal("lenRtype", n, 4);
    runQueue(100);

    addInstr(OP_LOAD, 1'b0, 0, 2, 0, n);
    checkVal("lenLwStall2", n, 7);
    runQueue(100);

    addInstr(OP_STORE, 1'b0, 1, 0, 0, n);
    checkVal("lenSwFetchStall", n, 5);
    runQueue(100);

    addInstr(OP_BRANCH, 1'b1, 0, 0, 0, n);
    checkVal("lenBeq", n, 3);
    addInstr(OP_BRANCH, 1'b0, 0, 0, 0, n);
    addInstr(OP_ITYPE, 1'b0, 0, 0, 0, n);
    checkVal("lenItype", n, 4);
    addInstr(OP_JAL, 1'b0, 0, 0, 0, n);
    checkVal("lenJal", n, 4);
    addInstr(OP_LOAD, 1'b0, 2, 1, 0, n);
    checkVal("lenLwMixedStall", n, 8);
    addInstr(OP_STORE, 1'b0, 0, 2, 0, n);
    runQueue(200);

    addInstr(OP_BAD, 1'b0, 0, 0, 12, n);
    runQueue(100);
    doReset();
    addInstr(OP_RTYPE, 1'b0, 0, 0, 0, n);
    runQueue(100);

    // Store parked in MEMWRITE, then reset lands between clock edges
    addInstr(OP_STORE, 1'b0, 0, 3, 0, n);
    runQueue(4);
    memReady = 1'b0;
    #2 checkVal("memWriteBeforeReset", 32'(memWrite), 1);
    reset = 1'b1;
    #1 checkVal("memWriteAsyncDrop", 32'(memWrite), 0);
    checkVal("allOutAsyncDrop", 32'(vec), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    addStep(P_HOLD, 7'd0, -1, -1);
    addStep(P_HOLD, 7'd0, -1, -1);
    addInstr(OP_LOAD, 1'b0, 0, 0, 0, n);
    checkVal("lenLw", n, 5);
    addInstr(OP_BRANCH, 1'b1, 0, 0, 0, n);
    runQueue(100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
